iface_with_multiple_initials: RTL and testbench
===============================================

// Module: iface_with_multiple_initials
// PURPOSE
//  Startup banner emitter: after reset, streams three fixed ASCII messages byte-by-byte over a valid/ready port.
//  Message 1 embeds the instance name; messages 2 and 3 are constant.
//  Sits beside a console/UART sink; gives a deterministic, ordered replacement for multiple unordered init-time prints.
//  MSG1 = "Initial block 1: " + NAME + LF, MSG2 = "Initial block 2" + LF, MSG3 = "Initial block 3" + LF.
// PARAMETERS
//  NAME_LEN  10            number of name characters, 0..32
//  NAME      "TEST_IFACE"  instance name, NAME_LEN*8 bits, first character in MSBs
// PORTS
//  clk        in   1  single clock, all state rising-edge
//  rst_n      in   1  asynchronous, active-low reset
//  char_o     out  8  current ASCII byte
//  valid_o    out  1  char_o holds a byte to transfer
//  ready_i    in   1  sink accepts; transfer = valid_o & ready_i at clk rise
//  msg_idx_o  out  2  message being sent: 0=MSG1, 1=MSG2, 2=MSG3
//  last_o     out  1  current byte is the LF terminating its message
//  done_o     out  1  all three messages transferred
// BEHAVIOUR
//  Reset, while rst_n=0: valid_o=0, char_o=0, msg_idx_o=0, last_o=0, done_o=0; position counter=0.
//  Assertion of rst_n takes effect immediately; deassertion is synchronised to clk.
//  States: SEND0 -> SEND1 -> SEND2 -> DONE; reset enters SEND0.
//  First rising edge after rst_n deasserts: valid_o=1, char_o='I' (8'h49), msg_idx_o=0.
//  All outputs are registered; no combinational path from ready_i to any output.
//  Valid/ready rules:
//   - valid_o never drops without a transfer.
//   - char_o, msg_idx_o and last_o hold stable while valid_o=1 and ready_i=0.
//   - On a transfer, the next byte is presented in the following cycle.
//   - Back-to-back transfers give one byte per cycle with no bubbles.
//  Message lengths: MSG1 = 17+NAME_LEN+1 bytes (28 at default); MSG2 = MSG3 = 16 bytes.
//  Boundaries and ordering:
//   - last_o=1 only on the LF byte (8'h0A).
//   - On transfer of an LF: position counter wraps to 0 and msg_idx increments.
//   - Messages are always sent in order MSG1, MSG2, MSG3; no gap between them.
//  NAME_LEN=0: MSG1 = "Initial block 1: " + LF (18 bytes).
//  Completion and abort:
//   - On transfer of the MSG3 LF: valid_o=0 and done_o=1 next cycle.
//   - DONE state is held until the next reset; ready_i is ignored in DONE.
//   - Reset mid-stream aborts at once; the stream restarts from MSG1 byte 0.
//  The ready_i value while valid_o=0 is don't-care.
// STRUCTURE
//  Package iwmi_pkg holds:
//   - state enum {SEND0, SEND1, SEND2, DONE};
//   - constants PREFIX1 "Initial block 1: " (17 B), MSG2_TXT and MSG3_TXT (15 B each);
//   - constant LF = 8'h0A and the length constants.
//  One sub-module, iwmi_char_rom: combinational; (msg_idx, pos, NAME) -> byte.
//  Top level: state register, position counter, output registers and handshake.
// TESTING
//  ready_i=1 permanently -> 60 contiguous bytes, exactly "Initial block 1: TEST_IFACE\nInitial block 2\nInitial block 3\n".
//   - In this run last_o pulses at byte indices 27, 43 and 59.
//   - done_o=1 the cycle after byte 59.
//  Random ready_i (50%) -> the same 60-byte sequence; char_o is stable whenever valid_o=1 and ready_i=0.
//  ready_i=0 for 20 cycles after reset -> valid_o=1 and char_o=8'h49 held for all 20 cycles.
//  rst_n pulsed low at byte 35 -> valid_o=0 immediately; the stream restarts with 'I', msg_idx_o=0.
//  NAME_LEN=0 -> MSG1 = "Initial block 1: \n" (18 B); 50 bytes in total.
//  After done_o -> toggling ready_i for 100 cycles: valid_o stays 0 and done_o stays 1.

Source files
------------

// File: rtl/iwmi_pkg.sv
// Shared types and constants for the startup banner emitter.
// Holds the state encoding, the fixed message texts, the LF terminator and
// the byte-length constants used by the character ROM and the top level.
package iwmi_pkg;

    typedef enum logic [1:0] {
        SEND0 = 2'd0,
        SEND1 = 2'd1,
        SEND2 = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [7:0] LF = 8'h0A;

    localparam int PREFIX1_BYTES = 17;
    localparam int BODY_BYTES    = 15;

    localparam logic [PREFIX1_BYTES*8-1:0] PREFIX1  = "Initial block 1: ";
    localparam logic [BODY_BYTES*8-1:0]    MSG2_TXT = "Initial block 2";
    localparam logic [BODY_BYTES*8-1:0]    MSG3_TXT = "Initial block 3";

    // 6-bit copies so position compares need no width juggling
    localparam logic [5:0] PREFIX1_LEN = 6'd17;
    localparam logic [5:0] BODY_LEN    = 6'd15;

    function automatic state_e next_send(input state_e s);
        case (s)
            SEND0:   return SEND1;
            SEND1:   return SEND2;
            default: return DONE;
        endcase
    endfunction

endpackage

// File: rtl/iwmi_char_rom.sv
// Character ROM: maps (message index, byte position) to the ASCII byte.
// Purely combinational, zero latency; no handshake of its own.
// Ports: msg_idx_i/pos_i select the byte, char_o is the byte, last_o flags
// the LF that ends the selected message. Message 0 embeds NAME.
module iwmi_char_rom
    import iwmi_pkg::*;
#(
    parameter int NAME_LEN = 10,
    parameter logic [((NAME_LEN > 0) ? NAME_LEN : 1)*8-1:0] NAME = "TEST_IFACE"
) (
    input  logic [1:0] msg_idx_i,
    input  logic [5:0] pos_i,
    output logic [7:0] char_o,
    output logic       last_o
);

    localparam logic [5:0] NAME_END = PREFIX1_LEN + 6'(NAME_LEN);

    logic [5:0] name_k;

    always_comb begin
        char_o = LF;
        last_o = 1'b0;
        name_k = pos_i - PREFIX1_LEN;
        case (msg_idx_i)
            2'd0: begin
                // Strings are stored first character in the MSBs, so index
                // from the top byte down.
                if (pos_i < PREFIX1_LEN) begin
                    char_o = 8'(PREFIX1 >> {(PREFIX1_LEN - 6'd1 - pos_i), 3'b000});
                end else if (pos_i < NAME_END) begin
                    char_o = 8'(NAME >> {(6'(NAME_LEN) - 6'd1 - name_k), 3'b000});
                end else begin
                    last_o = 1'b1;
                end
            end
            2'd1: begin
                if (pos_i < BODY_LEN) begin
                    char_o = 8'(MSG2_TXT >> {(BODY_LEN - 6'd1 - pos_i), 3'b000});
                end else begin
                    last_o = 1'b1;
                end
            end
            2'd2: begin
                if (pos_i < BODY_LEN) begin
                    char_o = 8'(MSG3_TXT >> {(BODY_LEN - 6'd1 - pos_i), 3'b000});
                end else begin
                    last_o = 1'b1;
                end
            end
            default: begin
                char_o = 8'h00;
            end
        endcase
    end

endmodule

// File: rtl/iface_with_multiple_initials.sv
// Startup banner emitter: streams MSG1 (with NAME), MSG2, MSG3 once after reset.
// Latency: first byte valid one clk after reset release; one byte/cycle when ready.
// Backpressure: valid/ready; outputs registered and held while ready_i=0.
// Ports: clk/rst_n; char_o, valid_o, ready_i form the byte stream;
// msg_idx_o names the message in flight, last_o marks its LF, done_o is
// sticky once the final LF has been accepted.
module iface_with_multiple_initials
    import iwmi_pkg::*;
#(
    parameter int NAME_LEN = 10,
    parameter logic [((NAME_LEN > 0) ? NAME_LEN : 1)*8-1:0] NAME = "TEST_IFACE"
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [7:0] char_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic [1:0] msg_idx_o,
    output logic       last_o,
    output logic       done_o
);

    state_e     state_q, state_d;
    logic [5:0] pos_q, pos_d;
    logic [7:0] char_q, char_d;
    logic       valid_q, valid_d;
    logic       last_q, last_d;
    logic [1:0] idx_q, idx_d;
    logic       done_q, done_d;

    logic [1:0] rom_msg;
    logic [5:0] rom_pos;
    logic [7:0] rom_char;
    logic       rom_last;

    iwmi_char_rom #(
        .NAME_LEN (NAME_LEN),
        .NAME     (NAME)
    ) u_rom (
        .msg_idx_i (rom_msg),
        .pos_i     (rom_pos),
        .char_o    (rom_char),
        .last_o    (rom_last)
    );

    // Address of the byte to present next: the very first byte after reset,
    // the start of the following message after an LF, otherwise pos+1.
    always_comb begin
        rom_msg = idx_q;
        rom_pos = pos_q + 6'd1;
        if (!valid_q) begin
            rom_msg = 2'd0;
            rom_pos = 6'd0;
        end else if (last_q) begin
            rom_msg = idx_q + 2'd1;
            rom_pos = 6'd0;
        end
    end

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        char_d  = char_q;
        valid_d = valid_q;
        last_d  = last_q;
        idx_d   = idx_q;
        done_d  = done_q;
        // valid_q is low outside DONE only in the cycle after reset, which
        // is when the first byte gets loaded.
        if ((state_q != DONE) && (!valid_q || ready_i)) begin
            if (valid_q && last_q && (state_q == SEND2)) begin
                state_d = DONE;
                valid_d = 1'b0;
                char_d  = 8'h00;
                last_d  = 1'b0;
                done_d  = 1'b1;
            end else begin
                if (valid_q && last_q) begin
                    state_d = next_send(state_q);
                end
                pos_d   = rom_pos;
                idx_d   = rom_msg;
                char_d  = rom_char;
                last_d  = rom_last;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEND0;
            pos_q   <= 6'd0;
            char_q  <= 8'h00;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            idx_q   <= 2'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            char_q  <= char_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    assign char_o    = char_q;
    assign valid_o   = valid_q;
    assign msg_idx_o = idx_q;
    assign last_o    = last_q;
    assign done_o    = done_q;

endmodule

// File: tb/tb_iface_with_multiple_initials.sv
module tb_iface_with_multiple_initials;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ready_i = 1'b0;
    logic [7:0] char_o;
    logic       valid_o;
    logic [1:0] msg_idx_o;
    logic       last_o;
    logic       done_o;

    logic       rst2_n = 1'b0;
    logic       ready2 = 1'b0;
    logic [7:0] char2;
    logic       valid2;
    logic [1:0] idx2;
    logic       last2;
    logic       done2;

    always #5 clk = ~clk;

    iface_with_multiple_initials dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .char_o    (char_o),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .msg_idx_o (msg_idx_o),
        .last_o    (last_o),
        .done_o    (done_o)
    );

    iface_with_multiple_initials #(
        .NAME_LEN (0),
        .NAME     (8'h00)
    ) dut0 (
        .clk       (clk),
        .rst_n     (rst2_n),
        .char_o    (char2),
        .valid_o   (valid2),
        .ready_i   (ready2),
        .msg_idx_o (idx2),
        .last_o    (last2),
        .done_o    (done2)
    );

    typedef struct packed {
        logic [7:0] ch;
        logic [1:0] idx;
        logic       last;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   n_xfer = 0;
    logic mon_en = 1'b0;

    logic       prev_vld = 1'b0, prev_rdy = 1'b0, prev_done = 1'b0, prev_xlast = 1'b0;
    logic [7:0] prev_ch = 8'h00;
    logic [1:0] prev_idx = 2'd0;
    logic       prev_last = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic string msg_text(input int m, input string nm);
        if (m == 0) return {"Initial block 1: ", nm, "\n"};
        if (m == 1) return "Initial block 2\n";
        return "Initial block 3\n";
    endfunction

    // Reference: the three messages as plain strings, one entry per byte.
    task automatic push_stream(input string nm);
        string s;
        exp_t  e;
        for (int m = 0; m < 3; m++) begin
            s = msg_text(m, nm);
            for (int i = 0; i < s.len(); i++) begin
                e.ch   = s[i];
                e.idx  = 2'(m);
                e.last = (i == s.len() - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    // Monitor: pops the scoreboard on every accepted byte, and checks hold
    // stability under backpressure and done timing.
    always @(negedge clk) begin
        exp_t e;
        logic xl;
        if (!rst_n) begin
            prev_vld = 1'b0; prev_rdy = 1'b0; prev_done = 1'b0; prev_xlast = 1'b0;
        end else if (mon_en) begin
            if (prev_vld && !prev_rdy) begin
                check("hold_valid", valid_o, 1);
                check("hold_char", char_o, prev_ch);
                check("hold_idx", msg_idx_o, prev_idx);
                check("hold_last", last_o, prev_last);
            end
            if (done_o && !prev_done) check("done_after_last_lf", prev_xlast, 1);
            xl = 1'b0;
            if (valid_o && ready_i) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL extra_byte: got 0x%0h, required no byte", char_o);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("char[%0d]", n_xfer), char_o, e.ch);
                    check($sformatf("idx[%0d]", n_xfer), msg_idx_o, e.idx);
                    check($sformatf("last[%0d]", n_xfer), last_o, e.last);
                end
                n_xfer++;
                xl = last_o && (msg_idx_o == 2'd2);
            end
            prev_vld = valid_o; prev_rdy = ready_i; prev_ch = char_o;
            prev_idx = msg_idx_o; prev_last = last_o; prev_done = done_o; prev_xlast = xl;
        end
    end

    task automatic wait_done(input int limit, input logic rnd, input string nm);
        int c = 0;
        while (!done_o && c < limit) begin
            @(posedge clk); #1;
            if (rnd) ready_i = 1'($urandom_range(0, 1));
            c++;
        end
        @(negedge clk);
        check({nm, "_done"}, done_o, 1);
        check({nm, "_count"}, n_xfer, 60);
        check({nm, "_queue_empty"}, exp_q.size(), 0);
    endtask

    task automatic start_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("rst_valid_immediate", valid_o, 0);
        check("rst_idx_immediate", msg_idx_o, 0);
        check("rst_done_immediate", done_o, 0);
        exp_q.delete();
        push_stream("TEST_IFACE");
        n_xfer = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int c;
        string s0;
        mon_en = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_valid", valid_o, 0);
        check("reset_char", char_o, 0);
        check("reset_idx", msg_idx_o, 0);
        check("reset_last", last_o, 0);
        check("reset_done", done_o, 0);

        // Hold 'I' under 20 cycles of backpressure, then stream at full rate.
        push_stream("TEST_IFACE");
        n_xfer = 0;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("stall_valid", valid_o, 1);
            check("stall_char", char_o, 8'h49);
        end
        @(posedge clk); #1;
        ready_i = 1'b1;
        wait_done(200, 1'b0, "full_rate");

        // DONE is sticky and ignores ready_i.
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            ready_i = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("post_done_valid", valid_o, 0);
            check("post_done_done", done_o, 1);
        end

        // Random 50% backpressure.
        ready_i = 1'b0;
        start_reset();
        wait_done(2000, 1'b1, "random_ready");

        // Abort at byte 35 and restart.
        ready_i = 1'b1;
        start_reset();
        c = 0;
        while (n_xfer < 35 && c < 200) begin
            @(posedge clk); #1;
            c++;
        end
        check("abort_reached_35", n_xfer, 35);
        start_reset();
        wait_done(200, 1'b0, "after_abort");

        // Empty name instance.
        s0 = {msg_text(0, ""), msg_text(1, ""), msg_text(2, "")};
        c = 0;
        @(negedge clk);
        rst2_n = 1'b1;
        ready2 = 1'b1;
        for (int i = 0; i < 120 && !done2; i++) begin
            @(negedge clk);
            if (valid2 && ready2) begin
                if (c < s0.len()) begin
                    check($sformatf("n0_char[%0d]", c), char2, s0[c]);
                    check($sformatf("n0_last[%0d]", c), last2, (c == 17 || c == 33 || c == 49));
                    check($sformatf("n0_idx[%0d]", c), idx2, (c < 18) ? 0 : (c < 34) ? 1 : 2);
                end
                c++;
            end
        end
        @(negedge clk);
        check("n0_count", c, 50);
        check("n0_done", done2, 1);
        check("n0_valid_low", valid2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
